scheduler_weighted: RTL and testbench
=====================================

Name: scheduler_weighted

Overview:
Parametrised successor to the fetch-stage thread schedulers. Each cycle it selects the next hardware thread to issue, using:
- round-robin order over ready threads, skipping stalled and inactive threads;
- two priority classes, with a starvation guard for the low class;
- a per-thread burst weight, so a thread may keep the slot for several consecutive cycles;
- an exception redirect that overrides all of the above.

It sits between the per-thread stall/status logic and the fetch stage. Its registered output drives the thread select.

Parameters:
N_THREADS, 8, number of hardware threads (2..32)
TID_W, $clog2(N_THREADS), width of a thread id
WEIGHT_W, 4, width of a per-thread burst weight
STARVE_LIMIT, 4, consecutive high-class grants allowed while a low-class thread waits

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
stalled  in  N_THREADS  per-thread stall flag
active  in  N_THREADS  per-thread enable mask (0 = thread parked)
exc_en  in  1  exception redirect request
exc_thread  in  TID_W  thread to redirect to; must be < N_THREADS (assertion otherwise)
cfg_we  in  1  configuration write strobe
cfg_thread  in  TID_W  thread whose configuration is written
cfg_weight  in  WEIGHT_W  burst length in cycles; 0 is treated as 1
cfg_prio  in  1  class: 1 = high, 0 = low
thread  out  TID_W  selected thread (registered)
thread_valid  out  1  thread is a valid issue slot (registered)

Behaviour:
- Reset values:
  - thread=0, thread_valid=0
  - ptr=N_THREADS-1, so the first grant searches from thread 0
  - burst_cnt=0, starve_cnt=0
  - all weight=1, all prio=0
- Latency: inputs sampled at edge k determine thread/thread_valid after edge k. One-cycle registered decision, no combinational input-to-output path.
- Eligibility: elig[t] = active[t] & ~stalled[t].
- Decision precedence, evaluated each cycle:
  1. rst
  2. exc_en
  3. hold
  4. select
  5. idle
- exc_en:
  - thread<=exc_thread, thread_valid<=1, ptr<=exc_thread, burst_cnt<=0.
  - Ignores stalled, active and burst; starve_cnt unchanged.
- Hold: applies when thread_valid=1, elig[thread]=1 and burst_cnt < eff_weight(thread)-1.
  - thread is unchanged; burst_cnt++.
- Select: applies when hold fails and at least one thread is eligible.
  - Class choice:
    - low class when starve_cnt==STARVE_LIMIT and some low-class thread is eligible;
    - otherwise high class if any high-class thread is eligible;
    - otherwise low class.
  - Within the chosen class, pick the first eligible thread scanning ptr+1, ptr+2, ... modulo N_THREADS. ptr itself is checked last.
  - On grant: thread<=pick, ptr<=pick, burst_cnt<=0, thread_valid<=1.
- Idle (no thread eligible): thread_valid<=0, thread holds its old value, burst_cnt<=0, ptr unchanged.
- starve_cnt, updated only on select:
  - resets to 0 when a low-class thread is granted;
  - increments, saturating at STARVE_LIMIT, when a high-class thread is granted while any low-class thread is eligible;
  - otherwise unchanged.
- Configuration:
  - A cfg_we write updates weight/prio at the clock edge; it affects decisions from the following cycle onward.
  - A write to the currently held thread does not restart burst_cnt.
  - A write in the same cycle as rst is discarded.
- Wrap-around: scan and ptr arithmetic are modulo N_THREADS for non-power-of-two counts; ptr never holds a value >= N_THREADS.
- Weight counter width is WEIGHT_W; eff_weight = max(weight,1).

Decomposition:
- Shared package (common): n_threads/threadid_t parametrised from N_THREADS, plus new typedefs weight_t (WEIGHT_W bits) and prio_t (1 bit) and constant STARVE_LIMIT default.
- One combinational sub-module, rr_pick:
  - inputs: request vector, ptr;
  - outputs: found flag, picked id.
  - Instantiated twice, for the high- and low-class request vectors.
- Config registers, counters and the decision FSM live in the top module.

Test Plan:
- Reset then all active, none stalled, default config → thread sequence 0,1,2,...,7,0 with thread_valid=1 from the first post-reset cycle.
- Threads 2 and 5 stalled → sequence 0,1,3,4,6,7,0; stall all threads → thread_valid=0 next cycle, thread holds; unstall thread 4 → thread=4, valid=1.
- cfg thread 3 weight=3, others 1 → ...,2,3,3,3,4,...; stall thread 3 after its second cycle → next grant is 4 and burst ends early.
- Thread 7 prio=0, others prio=1, STARVE_LIMIT=4, all eligible → thread 7 granted once after every 4 high-class grants, then starve_cnt returns to 0.
- exc_en=1, exc_thread=6 while thread 1 is mid-burst and thread 6 is stalled → thread=6 next cycle; following round-robin grant resumes from thread 7.
- N_THREADS=5 instance, assert rst mid-burst → all state returns to reset values; sequence restarts 0,1,2,3,4,0.

Source files
------------

// File: rtl/scheduler_weighted_pkg.sv
// Shared types and default sizing for the weighted fetch-thread scheduler.
package scheduler_weighted_pkg;

  localparam int N_THREADS_DEF    = 8;
  localparam int TID_W_DEF        = $clog2(N_THREADS_DEF);
  localparam int WEIGHT_W_DEF     = 4;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef logic [TID_W_DEF-1:0]    threadid_t;
  typedef logic [WEIGHT_W_DEF-1:0] weight_t;
  typedef logic                    prio_t;

  typedef enum logic [1:0] {
    DEC_EXC,
    DEC_HOLD,
    DEC_SEL,
    DEC_IDLE
  } dec_e;

endpackage

// File: rtl/scheduler_weighted_rr_pick.sv
// Round-robin finder: first set request after ptr, wrapping, with ptr itself checked last.
module scheduler_weighted_rr_pick
  import scheduler_weighted_pkg::*;
#(
  parameter int N_THREADS = N_THREADS_DEF,
  parameter int TID_W     = $clog2(N_THREADS)
) (
  input  logic [N_THREADS-1:0] req,
  input  logic [TID_W-1:0]     ptr,
  output logic                 found,
  output logic [TID_W-1:0]     pick
);

  always_comb begin
    found = 1'b0;
    pick  = '0;
    // Upper segment (ptr+1 .. N-1) wins over the wrapped segment (0 .. ptr).
    for (int t = 0; t < N_THREADS; t++) begin
      if (!found && req[t] && (t > int'(ptr))) begin
        found = 1'b1;
        pick  = TID_W'(t);
      end
    end
    for (int t = 0; t < N_THREADS; t++) begin
      if (!found && req[t] && (t <= int'(ptr))) begin
        found = 1'b1;
        pick  = TID_W'(t);
      end
    end
  end

endmodule

// File: rtl/scheduler_weighted.sv
// Fetch thread scheduler: round-robin over eligible threads with two priority
// classes, low-class starvation guard, per-thread burst weights and exception redirect.
module scheduler_weighted
  import scheduler_weighted_pkg::*;
#(
  parameter int N_THREADS    = N_THREADS_DEF,
  parameter int TID_W        = $clog2(N_THREADS),
  parameter int WEIGHT_W     = WEIGHT_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_THREADS-1:0] stalled,
  input  logic [N_THREADS-1:0] active,
  input  logic                 exc_en,
  input  logic [TID_W-1:0]     exc_thread,
  input  logic                 cfg_we,
  input  logic [TID_W-1:0]     cfg_thread,
  input  logic [WEIGHT_W-1:0]  cfg_weight,
  input  logic                 cfg_prio,
  output logic [TID_W-1:0]     thread,
  output logic                 thread_valid
);

  localparam int                 SC_W       = $clog2(STARVE_LIMIT + 2);
  localparam logic [SC_W-1:0]    STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [TID_W:0]     N_LIM      = (TID_W+1)'(N_THREADS);
  localparam logic [TID_W-1:0]   PTR_RST    = TID_W'(N_THREADS - 1);

  logic [WEIGHT_W-1:0]  weight [N_THREADS];
  logic [N_THREADS-1:0] prio;
  logic [TID_W-1:0]     ptr;
  logic [WEIGHT_W-1:0]  burst_cnt;
  logic [SC_W-1:0]      starve_cnt;

  logic [N_THREADS-1:0] elig, hi_req, lo_req;
  logic                 hi_found, lo_found, use_lo, hold;
  logic [TID_W-1:0]     hi_pick, lo_pick, pick;
  logic [WEIGHT_W-1:0]  cur_w;
  dec_e                 dec;

  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  assign elig   = active & ~stalled;
  assign hi_req = elig & prio;
  assign lo_req = elig & ~prio;

  scheduler_weighted_rr_pick #(.N_THREADS(N_THREADS), .TID_W(TID_W)) u_pick_hi (
    .req   (hi_req),
    .ptr   (ptr),
    .found (hi_found),
    .pick  (hi_pick)
  );

  scheduler_weighted_rr_pick #(.N_THREADS(N_THREADS), .TID_W(TID_W)) u_pick_lo (
    .req   (lo_req),
    .ptr   (ptr),
    .found (lo_found),
    .pick  (lo_pick)
  );

  // Burst continues while burst_cnt < eff_weight-1, compared one bit wider to avoid wrap.
  always_comb begin
    cur_w  = eff_weight(weight[thread]);
    hold   = thread_valid && elig[thread] &&
             (({1'b0, burst_cnt} + (WEIGHT_W+1)'(1)) < {1'b0, cur_w});
    use_lo = ((starve_cnt == STARVE_MAX) && lo_found) || !hi_found;
    pick   = use_lo ? lo_pick : hi_pick;
    if (exc_en)                  dec = DEC_EXC;
    else if (hold)               dec = DEC_HOLD;
    else if (hi_found || lo_found) dec = DEC_SEL;
    else                         dec = DEC_IDLE;
  end

  // Decision register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      thread       <= '0;
      thread_valid <= 1'b0;
      ptr          <= PTR_RST;
      burst_cnt    <= '0;
      starve_cnt   <= '0;
      prio         <= '0;
      for (int i = 0; i < N_THREADS; i++) weight[i] <= WEIGHT_W'(1);
    end else begin
      case (dec)
        DEC_EXC: begin
          thread       <= exc_thread;
          thread_valid <= 1'b1;
          ptr          <= exc_thread;
          burst_cnt    <= '0;
        end
        DEC_HOLD: begin
          burst_cnt <= burst_cnt + WEIGHT_W'(1);
        end
        DEC_SEL: begin
          thread       <= pick;
          thread_valid <= 1'b1;
          ptr          <= pick;
          burst_cnt    <= '0;
          if (use_lo)
            starve_cnt <= '0;
          else if (lo_found && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + SC_W'(1);
        end
        default: begin
          thread_valid <= 1'b0;
          burst_cnt    <= '0;
        end
      endcase
      if (cfg_we && ({1'b0, cfg_thread} < N_LIM)) begin
        weight[cfg_thread] <= cfg_weight;
        prio[cfg_thread]   <= cfg_prio;
      end
    end
  end

  a_exc_range: assert property (@(posedge clk) disable iff (rst)
    exc_en |-> ({1'b0, exc_thread} < N_LIM));

endmodule

// File: tb/tb_scheduler_weighted.sv
// Directed bench for scheduler_weighted: vector table on an 8-thread instance,
// hand sequences for exception redirect and mid-burst reset on a 5-thread instance.
module tb_scheduler_weighted;

  logic       clk;
  logic       rst;
  logic [7:0] stalled, active;
  logic       exc_en;
  logic [2:0] exc_thread;
  logic       cfg_we;
  logic [2:0] cfg_thread;
  logic [3:0] cfg_weight;
  logic       cfg_prio;
  logic [2:0] thread;
  logic       thread_valid;

  logic       rst5;
  logic [4:0] stalled5, active5;
  logic       exc_en5;
  logic [2:0] exc_thread5;
  logic       cfg_we5;
  logic [2:0] cfg_thread5;
  logic [3:0] cfg_weight5;
  logic       cfg_prio5;
  logic [2:0] thread5;
  logic       thread_valid5;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] stalled;
    logic [7:0] active;
    logic       cfg_we;
    logic [2:0] cfg_thread;
    logic [3:0] cfg_weight;
    logic       cfg_prio;
    logic [2:0] exp_thread;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[$];

  scheduler_weighted #(.N_THREADS(8), .WEIGHT_W(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .stalled(stalled), .active(active),
    .exc_en(exc_en), .exc_thread(exc_thread),
    .cfg_we(cfg_we), .cfg_thread(cfg_thread), .cfg_weight(cfg_weight), .cfg_prio(cfg_prio),
    .thread(thread), .thread_valid(thread_valid)
  );

  scheduler_weighted #(.N_THREADS(5), .WEIGHT_W(4), .STARVE_LIMIT(4)) dut5 (
    .clk(clk), .rst(rst5), .stalled(stalled5), .active(active5),
    .exc_en(exc_en5), .exc_thread(exc_thread5),
    .cfg_we(cfg_we5), .cfg_thread(cfg_thread5), .cfg_weight(cfg_weight5), .cfg_prio(cfg_prio5),
    .thread(thread5), .thread_valid(thread_valid5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic [7:0] st, input logic [7:0] act,
                              input logic we, input logic [2:0] ct, input logic [3:0] cw,
                              input logic cp, input logic [2:0] et, input logic ev);
    vec_t v;
    v.stalled = st; v.active = act; v.cfg_we = we; v.cfg_thread = ct;
    v.cfg_weight = cw; v.cfg_prio = cp; v.exp_thread = et; v.exp_valid = ev;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [2:0] act_t, input logic act_v,
                       input logic [2:0] exp_t, input logic exp_v);
    checks++;
    if (act_t !== exp_t || act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got thread=%0d valid=%0d, expected thread=%0d valid=%0d",
               name, act_t, act_v, exp_t, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] st, input logic [7:0] act, input logic ex,
                       input logic [2:0] ext, input logic we, input logic [2:0] ct,
                       input logic [3:0] cw, input logic cp);
    stalled = st; active = act; exc_en = ex; exc_thread = ext;
    cfg_we = we; cfg_thread = ct; cfg_weight = cw; cfg_prio = cp;
  endtask

  task automatic drive5(input logic r, input logic we, input logic [2:0] ct, input logic [3:0] cw);
    rst5 = r; cfg_we5 = we; cfg_thread5 = ct; cfg_weight5 = cw; cfg_prio5 = 1'b0;
  endtask

  initial begin
    logic [2:0] seq5 [6];

    // Round robin, default config
    for (int t = 1; t < 8; t++) add(8'h00, 8'hFF, 0, 0, 0, 0, 3'(t), 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd0, 1);
    // Thread 0 first: prepend so the sequence reads 0..7,0
    vecs.push_front('{8'h00, 8'hFF, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 1'b1});
    // Threads 2 and 5 stalled
    add(8'h24, 8'hFF, 0, 0, 0, 0, 3'd1, 1);
    add(8'h24, 8'hFF, 0, 0, 0, 0, 3'd3, 1);
    add(8'h24, 8'hFF, 0, 0, 0, 0, 3'd4, 1);
    add(8'h24, 8'hFF, 0, 0, 0, 0, 3'd6, 1);
    add(8'h24, 8'hFF, 0, 0, 0, 0, 3'd7, 1);
    add(8'h24, 8'hFF, 0, 0, 0, 0, 3'd0, 1);
    // All stalled: idle, thread holds; then only 4 eligible
    add(8'hFF, 8'hFF, 0, 0, 0, 0, 3'd0, 0);
    add(8'hFF, 8'hFF, 0, 0, 0, 0, 3'd0, 0);
    add(8'hEF, 8'hFF, 0, 0, 0, 0, 3'd4, 1);
    add(8'hEF, 8'hFF, 0, 0, 0, 0, 3'd4, 1);
    // Parked threads 4..7 are skipped, wrap to 0
    add(8'h00, 8'h0F, 0, 0, 0, 0, 3'd0, 1);
    // Thread 3 weight 3 written now, effective from next decision
    add(8'h00, 8'hFF, 1, 3'd3, 4'd3, 0, 3'd1, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd2, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd3, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd3, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd3, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd4, 1);
    for (int t = 5; t < 8; t++) add(8'h00, 8'hFF, 0, 0, 0, 0, 3'(t), 1);
    for (int t = 0; t < 4; t++) add(8'h00, 8'hFF, 0, 0, 0, 0, 3'(t), 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd3, 1);
    // Stall 3 after its second cycle: burst ends early
    add(8'h08, 8'hFF, 0, 0, 0, 0, 3'd4, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd5, 1);
    // Weight 0 behaves as 1
    add(8'h00, 8'hFF, 1, 3'd6, 4'd0, 0, 3'd6, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd7, 1);
    // Rewriting the held thread's weight does not restart its burst
    for (int t = 0; t < 4; t++) add(8'h00, 8'hFF, 0, 0, 0, 0, 3'(t), 1);
    add(8'h00, 8'hFF, 1, 3'd3, 4'd3, 0, 3'd3, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd3, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd4, 1);
    // Reconfigure while parked: 0..6 high, 7 low, all weight 1
    for (int t = 0; t < 7; t++) add(8'h00, 8'h00, 1, 3'(t), 4'd1, 1, 3'd4, 0);
    add(8'h00, 8'h00, 1, 3'd7, 4'd1, 0, 3'd4, 0);
    // Starvation guard: 7 granted after every 4 high-class grants
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd5, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd6, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd0, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd1, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd7, 1);
    for (int t = 0; t < 4; t++) add(8'h00, 8'hFF, 0, 0, 0, 0, 3'(t), 1);
    add(8'h00, 8'hFF, 0, 0, 0, 0, 3'd7, 1);

    rst = 1'b1;
    drive(8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    rst5 = 1'b1; stalled5 = '0; active5 = '0; exc_en5 = 1'b0; exc_thread5 = '0;
    cfg_we5 = 1'b0; cfg_thread5 = '0; cfg_weight5 = '0; cfg_prio5 = 1'b0;
    step();
    step();
    check("reset8", thread, thread_valid, 3'd0, 1'b0);
    check("reset5", thread5, thread_valid5, 3'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stalled, vecs[i].active, 0, 0, vecs[i].cfg_we,
            vecs[i].cfg_thread, vecs[i].cfg_weight, vecs[i].cfg_prio);
      step();
      check($sformatf("vec%0d", i), thread, thread_valid, vecs[i].exp_thread, vecs[i].exp_valid);
    end

    // Exception redirect to a stalled thread while thread 1 is mid-burst
    drive(8'h00, 8'hFF, 0, 0, 1, 3'd1, 4'd3, 1);
    step(); check("exc_pre0", thread, thread_valid, 3'd0, 1'b1);
    drive(8'h00, 8'hFF, 0, 0, 1, 3'd7, 4'd1, 1);
    step(); check("exc_burst_a", thread, thread_valid, 3'd1, 1'b1);
    drive(8'h00, 8'hFF, 0, 0, 0, 0, 0, 0);
    step(); check("exc_burst_b", thread, thread_valid, 3'd1, 1'b1);
    drive(8'h40, 8'hFF, 1, 3'd6, 0, 0, 0, 0);
    step(); check("exc_redirect", thread, thread_valid, 3'd6, 1'b1);
    drive(8'h40, 8'hFF, 0, 0, 0, 0, 0, 0);
    step(); check("exc_resume", thread, thread_valid, 3'd7, 1'b1);
    drive(8'h00, 8'hFF, 0, 0, 0, 0, 0, 0);
    step(); check("exc_next", thread, thread_valid, 3'd0, 1'b1);

    // Five-thread instance: reset mid-burst, cfg during reset discarded
    active5 = 5'h1F;
    drive5(1'b0, 1'b1, 3'd1, 4'd2);
    step(); check("n5_first", thread5, thread_valid5, 3'd0, 1'b1);
    drive5(1'b0, 1'b0, 3'd0, 4'd0);
    step(); check("n5_burst_a", thread5, thread_valid5, 3'd1, 1'b1);
    step(); check("n5_burst_b", thread5, thread_valid5, 3'd1, 1'b1);
    drive5(1'b1, 1'b1, 3'd0, 4'd3);
    step(); check("n5_rst", thread5, thread_valid5, 3'd0, 1'b0);
    drive5(1'b0, 1'b0, 3'd0, 4'd0);
    seq5 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("n5_seq%0d", i), thread5, thread_valid5, seq5[i], 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
